wb_ram_arbiter: RTL
===================

# wb_ram_arbiter

Two-master Wishbone classic arbiter that shares one single-port `ram_wishbone` slave between an instruction-fetch master (M0) and a load/store master (M1) in the RISC-V SoC. It serialises requests with round-robin priority and issues exactly one single-cycle strobe per transaction, because the RAM acknowledges every strobed cycle one cycle later. It returns a one-cycle ACK and read data to the granted master.

## Interface
- `ADDRESS_WIDTH`, 8: address width, all ports
- `DATA_WIDTH`, 8: data width, all ports
- `TIMEOUT`, 15: WAIT cycles before error (used only with the macro)

- `CLK_I` in 1: clock, rising edge
- `RST_I` in 1: asynchronous, active-high reset
- `M0_STB_I`, `M1_STB_I` in 1: request; held high until the matching ACK/ERR
- `M0_WE_I`, `M1_WE_I` in 1: 1 = write
- `M0_ADR_I`, `M1_ADR_I` in ADDRESS_WIDTH: address
- `M0_DAT_I`, `M1_DAT_I` in DATA_WIDTH: write data
- `M0_DAT_O`, `M1_DAT_O` out DATA_WIDTH: read data; both driven from one shared capture register
- `M0_ACK_O`, `M1_ACK_O` out 1: one-cycle completion pulse
- `M0_ERR_O`, `M1_ERR_O` out 1: one-cycle timeout pulse; constant 0 without the macro
- `S_STB_O` out 1: strobe to RAM
- `S_WE_O` out 1: write enable to RAM
- `S_ADR_O` out ADDRESS_WIDTH: address to RAM
- `S_DAT_O` out DATA_WIDTH: write data to RAM
- `S_DAT_I` in DATA_WIDTH: read data from RAM
- `S_ACK_I` in 1: ack from RAM

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP (plus ERR with the macro).
- IDLE
  - Only one STB high: grant that master.
  - Both high: grant the master not granted last.
  - Neither high: stay in IDLE.
  - On grant: register the grant index, go to ISSUE.
- ISSUE
  - `S_STB_O`=1 for exactly this cycle.
  - `S_WE_O`, `S_ADR_O` and `S_DAT_O` mux the granted master's live inputs.
  - `S_ACK_I` is ignored. Next state is always WAIT.
- WAIT
  - `S_STB_O`=0; `S_WE_O`, `S_ADR_O` and `S_DAT_O` stay muxed to the granted master.
  - On `S_ACK_I`=1: if the transaction is a read, capture `S_DAT_I` into the read register; go to RESP.
- RESP
  - Granted master's `ACK_O`=1 for this single cycle; the other master's ACK stays 0.
  - Update last-grant to this master. Next state is always IDLE.
- The read register holds its value across writes and idle cycles.
- In the cycle after RESP, a master that has seen ACK may present a new STB; that STB is treated as a new request.
- Last-grant resets to M1, so M0 wins the first contended arbitration.
- `S_ACK_I` in IDLE or ISSUE is discarded. This covers the stray ack the RAM may emit after a reset aborts a strobe.
- Reset asserted in any state:
  - immediately: state=IDLE, every output and the read register = 0, last-grant=M1;
  - the in-flight transaction is dropped with no ACK.
- Master STB dropping before ACK is a protocol violation; the transaction still completes and ACK is still pulsed.

## Timing
- Master STB high at edge k (state IDLE) → ISSUE in cycle k+1 → WAIT in k+2, with RAM ACK in k+2 → master ACK in cycle k+3.
- Minimum latency is 3 cycles; throughput is one transaction per 4 cycles.
- Back-to-back contended requests alternate M0, M1, M0, …
- A lone requester is granted on every IDLE visit.

## Configuration
- Macro: `WB_ARB_TIMEOUT_EN`.
- Defined:
  - a counter of width $clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle without `S_ACK_I`;
  - when the counter reaches `TIMEOUT`, go to ERR: granted `ERR_O`=1 for one cycle, no ACK, last-grant updated, then IDLE;
  - an ACK arriving in the same cycle the counter hits `TIMEOUT` wins and the FSM goes to RESP.
- Undefined: no counter and no ERR state; WAIT waits indefinitely; `M*_ERR_O` tied 0.

## Test plan
- M0 read, addr 0x10 preloaded 0xA5: STB at cycle 0 → `S_STB_O` high only in cycle 1, `M0_ACK_O` high only in cycle 3, `M0_DAT_O`=0xA5.
- M1 write 0x3C to 0x20, then M0 read of 0x20 → M1 ACK; M0 reads 0x3C; `M0_DAT_O` unchanged by the write itself.
- Both STB held continuously for 4 transactions → grants in order M0, M1, M0, M1; ACKs at cycles 3, 7, 11, 15; never two ACKs in the same cycle.
- `RST_I` pulsed during WAIT → all outputs 0 immediately, no ACK; the stray `S_ACK_I` next cycle is ignored; the next M1 request completes in 3 cycles.
- With `WB_ARB_TIMEOUT_EN`, TIMEOUT=4, slave ACK stuck 0 → `M0_ERR_O` one pulse in cycle 7, `M0_ACK_O` never high; without the macro the FSM stays in WAIT and `ERR_O` stays 0.

Source files
------------

// File: rtl/wb_ram_arbiter.sv
// Purpose: two-master Wishbone classic arbiter sharing one single-port RAM slave (M0 = fetch, M1 = load/store).
// Latency: 3 cycles from master STB sampled in IDLE to the master ACK; one transaction per 4 cycles at most.
// Backpressure: masters hold STB until ACK/ERR; contended requests are served round-robin, one strobe per transaction.
//
// Ports: CLK_I/RST_I (async active-high); M0_*/M1_* master-side STB/WE/ADR/DAT in, DAT/ACK/ERR out;
//        S_* slave-side STB/WE/ADR/DAT out, DAT/ACK in. Both master DAT_O ports come from one capture register.
// Option: define WB_ARB_TIMEOUT_EN to add a WAIT-state timeout that ends the transaction with ERR_O instead of ACK_O.

module wb_ram_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int TIMEOUT       = 15
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     M0_STB_I,
    input  logic                     M0_WE_I,
    input  logic [ADDRESS_WIDTH-1:0] M0_ADR_I,
    input  logic [DATA_WIDTH-1:0]    M0_DAT_I,
    output logic [DATA_WIDTH-1:0]    M0_DAT_O,
    output logic                     M0_ACK_O,
    output logic                     M0_ERR_O,
    input  logic                     M1_STB_I,
    input  logic                     M1_WE_I,
    input  logic [ADDRESS_WIDTH-1:0] M1_ADR_I,
    input  logic [DATA_WIDTH-1:0]    M1_DAT_I,
    output logic [DATA_WIDTH-1:0]    M1_DAT_O,
    output logic                     M1_ACK_O,
    output logic                     M1_ERR_O,
    output logic                     S_STB_O,
    output logic                     S_WE_O,
    output logic [ADDRESS_WIDTH-1:0] S_ADR_O,
    output logic [DATA_WIDTH-1:0]    S_DAT_O,
    input  logic [DATA_WIDTH-1:0]    S_DAT_I,
    input  logic                     S_ACK_I
);

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP} state_t;
`endif

    state_t                   state, state_nxt;
    logic                     gnt;        // 0 = M0, 1 = M1; valid from ISSUE to RESP/ERR
    logic                     last_gnt;   // master that finished most recently
    logic                     gnt_pick;
    logic                     txn_done;
    logic                     bus_on;
    logic [DATA_WIDTH-1:0]    rd_dat;
    logic                     sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_adr;
    logic [DATA_WIDTH-1:0]    sel_dat;

    // Under contention the master not served last wins; a lone requester always wins.
    assign gnt_pick = (M0_STB_I && M1_STB_I) ? ~last_gnt : M1_STB_I;

    // Slave-side fields follow the granted master's live inputs, not a snapshot.
    assign sel_we  = gnt ? M1_WE_I  : M0_WE_I;
    assign sel_adr = gnt ? M1_ADR_I : M0_ADR_I;
    assign sel_dat = gnt ? M1_DAT_I : M0_DAT_I;
    assign bus_on  = (state == ISSUE) || (state == WAIT);

`ifdef WB_ARB_TIMEOUT_EN
    assign txn_done = (state == RESP) || (state == ERR);
`else
    assign txn_done = (state == RESP);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (M0_STB_I || M1_STB_I) state_nxt = ISSUE;
            // The RAM acks one cycle after the strobe, so any ACK seen here is stale.
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (S_ACK_I) begin
                    state_nxt = RESP;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (to_cnt == CNT_W'(TIMEOUT)) begin
                    state_nxt = ERR;
                end
`endif
            end
            RESP:  state_nxt = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
            ERR:   state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            rd_dat   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (M0_STB_I || M1_STB_I)) begin
                gnt <= gnt_pick;
            end
            if (txn_done) begin
                last_gnt <= gnt;
            end
            // Only reads update the capture register; writes leave the last read visible.
            if (state == WAIT && S_ACK_I && !sel_we) begin
                rd_dat <= S_DAT_I;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            to_cnt <= '0;
        end else if (state == ISSUE) begin
            to_cnt <= '0;
        end else if (state == WAIT && !S_ACK_I && to_cnt != CNT_W'(TIMEOUT)) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    assign M0_ERR_O = (state == ERR) && !gnt;
    assign M1_ERR_O = (state == ERR) &&  gnt;
`else
    assign M0_ERR_O = 1'b0;
    assign M1_ERR_O = 1'b0;
`endif

    // All outputs decode from registered state so reset clears them immediately.
    assign S_STB_O  = (state == ISSUE);
    assign S_WE_O   = bus_on && sel_we;
    assign S_ADR_O  = bus_on ? sel_adr : '0;
    assign S_DAT_O  = bus_on ? sel_dat : '0;
    assign M0_ACK_O = (state == RESP) && !gnt;
    assign M1_ACK_O = (state == RESP) &&  gnt;
    assign M0_DAT_O = rd_dat;
    assign M1_DAT_O = rd_dat;

endmodule
